// File: rtl/seg7_display_driver_if.sv
// Bus between the counter-word producer and the 7-segment display driver.
// load/busy: a load is accepted on a rising edge only while busy is low; busy stays high until the result commits.
interface seg7_display_driver_if;
  logic [31:0] value;
  logic        load;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  dbg_state;

  modport master (output value, load, input busy, seg, an, dbg_state);
  modport slave  (input value, load, output busy, seg, an, dbg_state);
endinterface

// File: rtl/seg7_display_driver.sv
// Converts value[15:0] to BCD with a one-shift-per-clock double-dabble engine
// and scans the committed digits onto a 4-digit multiplexed 7-segment display.
module seg7_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_LZ    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_display_driver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;

  localparam int              CW          = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]   REFRESH_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]      DASH        = 7'b1000000;
  localparam logic [6:0]      ZERO_GLYPH  = 7'b0111111;
  localparam bit              INV         = (ACTIVE_LOW != 0);

  state_t         state;
  logic           busy_q;
  logic [15:0]    bin_q;
  logic [19:0]    bcd_q;
  logic [3:0]     iter_q;
  logic [15:0]    disp_q;
  logic           ovf_q;
  logic [CW-1:0]  refresh_q;
  logic [1:0]     digit_sel_q;
  logic [6:0]     seg_q;
  logic [3:0]     an_q;

  logic [19:0]    bcd_adj;
  logic [19:0]    bcd_next;
  logic [15:0]    bin_next;
  logic           refresh_wrap;
  logic [CW-1:0]  refresh_d;
  logic [1:0]     sel_d;
  logic [3:0]     nib_d;
  logic           upper_zero;
  logic [6:0]     glyph_d;
  logic [3:0]     onehot_d;
  logic           unused_bits;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[18:0], bin_q[15]};
    bin_next = {bin_q[14:0], 1'b0};
  end

  // The upper half of the counter word and the adjusted MSB never matter.
  assign unused_bits = ^{bus.value[31:16], bcd_adj[19]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            bin_q  <= bus.value[15:0];
            bcd_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q  <= bcd_next;
          bin_q  <= bin_next;
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd15) state <= COMMIT;
        end
        COMMIT: begin
          disp_q <= bcd_q[15:0];
          ovf_q  <= |bcd_q[19:16];
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // an and seg are both registered from the next digit select so they stay aligned.
  always_comb begin
    refresh_wrap = (refresh_q == REFRESH_MAX);
    refresh_d    = refresh_wrap ? '0 : refresh_q + CW'(1);
    sel_d        = refresh_wrap ? digit_sel_q + 2'd1 : digit_sel_q;
    nib_d        = disp_q[{sel_d, 2'b00} +: 4];
    upper_zero   = ((disp_q >> {sel_d, 2'b00}) == 16'd0);
    onehot_d     = 4'b0001 << sel_d;
    if (ovf_q)
      glyph_d = DASH;
    else if ((BLANK_LZ != 0) && (sel_d != 2'd0) && upper_zero)
      glyph_d = 7'b0000000;
    else
      glyph_d = decode(nib_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q   <= '0;
      digit_sel_q <= '0;
      an_q        <= INV ? 4'b1110 : 4'b0001;
      seg_q       <= INV ? ~ZERO_GLYPH : ZERO_GLYPH;
    end else begin
      refresh_q   <= refresh_d;
      digit_sel_q <= sel_d;
      an_q        <= INV ? ~onehot_d : onehot_d;
      seg_q       <= INV ? ~glyph_d : glyph_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.dbg_state = state;

endmodule
